// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences each instruction through FETCH, DECODE,
// EXEC, MEM and WB, and drives the register file, IR, memory and ALU strobes.
// Memory accesses use a ready handshake with a bounded wait. A memory timeout
// or a HALT opcode parks the FSM in HALT until reset. Legal instructions are
// counted as they retire.
module multicycle_control_unit #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      instruction,
   input  logic             mem_ready,
   input  logic             zero,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic [1:0]       ALUOp,
   output logic             WdSel,
   output logic [2:0]       state,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_NAND = 4'h2;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   // wait_cnt only has to reach WAIT_MAX-1 before the timeout fires.
   localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

   state_t            cur_st;
   logic [WAIT_W-1:0] wait_cnt;
   logic [3:0]        opcode;
   logic              is_rtype;
   logic              is_mem;
   logic              is_beq;
   logic              is_legal;
   logic              timeout_hit;
   logic              unused_bits;

   assign opcode      = instruction[15:12];
   assign is_rtype    = (opcode == OP_ADD) || (opcode == OP_NAND);
   assign is_mem      = (opcode == OP_LW) || (opcode == OP_SW);
   assign is_beq      = (opcode == OP_BEQ);
   assign is_legal    = is_rtype || is_mem || is_beq;
   assign timeout_hit = (WAIT_MAX != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
   assign unused_bits = ^instruction[11:0];

   assign state  = cur_st;
   assign halted = (cur_st == S_HALT);

   // State, wait counter, sticky error flag and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_st      <= S_FETCH;
         wait_cnt    <= '0;
         mem_err     <= 1'b0;
         instr_count <= '0;
      end else begin
         // Any cycle that is not a memory wait (including every state change) clears the counter.
         wait_cnt <= '0;
         case (cur_st)
            S_FETCH: begin
               if (mem_ready) begin
                  cur_st <= S_DECODE;
               end else if (timeout_hit) begin
                  cur_st  <= S_HALT;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (opcode == OP_HALT) cur_st <= S_HALT;
               else if (!is_legal)    cur_st <= S_FETCH;
               else                   cur_st <= S_EXEC;
            end
            S_EXEC: begin
               if (is_beq) begin
                  cur_st      <= S_FETCH;
                  instr_count <= instr_count + 1'b1;
               end else if (is_rtype) begin
                  cur_st <= S_WB;
               end else if (is_mem) begin
                  cur_st <= S_MEM;
               end else begin
                  cur_st <= S_FETCH;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (opcode == OP_SW) begin
                     cur_st      <= S_FETCH;
                     instr_count <= instr_count + 1'b1;
                  end else begin
                     cur_st <= S_WB;
                  end
               end else if (timeout_hit) begin
                  cur_st  <= S_HALT;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB: begin
               cur_st      <= S_FETCH;
               instr_count <= instr_count + 1'b1;
            end
            S_HALT:  cur_st <= S_HALT;
            default: cur_st <= S_FETCH;
         endcase
      end
   end

   // Moore strobes from the current state; handshake and zero qualify them in the same cycle.
   always_comb begin
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      ALUOp    = 2'b00;
      WdSel    = 1'b0;
      if (!reset) begin
         case (cur_st)
            S_FETCH: begin
               MemRead = 1'b1;
               IRWrite = mem_ready;
            end
            S_DECODE: begin
               if (opcode != OP_HALT && !is_legal) PCWrite = 1'b1;
            end
            S_EXEC: begin
               if (opcode == OP_NAND) ALUOp = 2'b01;
               else if (is_beq)       ALUOp = 2'b10;
               if (is_beq) begin
                  PCWrite = 1'b1;
                  PCSrc   = zero;
               end
            end
            S_MEM: begin
               if (opcode == OP_SW) begin
                  MemWrite = 1'b1;
                  PCWrite  = mem_ready;
               end else begin
                  MemRead = 1'b1;
               end
            end
            S_WB: begin
               RegWrite = 1'b1;
               PCWrite  = 1'b1;
               WdSel    = (opcode == OP_LW);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Each instruction is expanded into a
// cycle-by-cycle script of inputs and expected outputs derived from the
// instruction's phase sequence, then played against the DUT.
module tb_multicycle_control_unit;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic [15:0]      instruction;
   logic             mem_ready;
   logic             zero;
   logic             IRWrite, MemRead, MemWrite, RegWrite, PCWrite, PCSrc, WdSel;
   logic [1:0]       ALUOp;
   logic [2:0]       state;
   logic             halted, mem_err;
   logic [CNT_W-1:0] instr_count;

   multicycle_control_unit #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
      .zero(zero), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .WdSel(WdSel), .state(state), .halted(halted), .mem_err(mem_err),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst, rdy, zer;
      logic [15:0] ins;
      logic [2:0]  st;
      logic        irw, mr, mw, rw, pcw, pcs, wds;
      logic [1:0]  alu;
      logic        ret, seterr;
   } ent_t;

   ent_t       cur[$];
   int         tests = 0;
   int         failed = 0;
   int         cyc = 0;
   logic [CNT_W-1:0] cnt_m;
   logic       err_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [3:0] op);
      return op == 4'h0 || op == 4'h2 || op == 4'hB || op == 4'h4 || op == 4'h5;
   endfunction

   // Fresh entry: given phase, don't-care inputs randomized.
   function automatic ent_t mk(input logic [2:0] st, input logic [15:0] ins);
      ent_t e;
      e     = '0;
      e.st  = st;
      e.ins = ins;
      e.rdy = 1'($urandom);
      e.zer = 1'($urandom);
      return e;
   endfunction

   task automatic halt_tail(input logic [15:0] ins);
      ent_t e;
      int n = $urandom_range(5, 20);
      for (int i = 0; i < n; i++) cur.push_back(mk(3'd7, ins));
      e = mk(3'd7, ins);
      e.rst = 1'b1;
      cur.push_back(e);
   endtask

   // Expand one instruction into its expected cycle sequence.
   task automatic build(input logic [3:0] op, input int fw, input int mw, input logic z,
                        input bit fto, input bit mto, input int abort_at);
      ent_t e;
      logic [15:0] ins = {op, 12'($urandom)};
      cur.delete();
      if (fto) begin
         for (int i = 0; i < WAIT_MAX; i++) begin
            e = mk(3'd0, ins); e.rdy = 1'b0; e.mr = 1'b1; e.seterr = (i == WAIT_MAX - 1);
            cur.push_back(e);
         end
         halt_tail(ins);
      end else begin
         for (int i = 0; i < fw; i++) begin
            e = mk(3'd0, ins); e.rdy = 1'b0; e.mr = 1'b1; cur.push_back(e);
         end
         e = mk(3'd0, ins); e.rdy = 1'b1; e.mr = 1'b1; e.irw = 1'b1; cur.push_back(e);
         e = mk(3'd1, ins);
         if (op == 4'hF) begin
            cur.push_back(e);
            halt_tail(ins);
         end else if (!legal(op)) begin
            e.pcw = 1'b1; cur.push_back(e);
         end else begin
            cur.push_back(e);
            e = mk(3'd2, ins);
            e.alu = (op == 4'h2) ? 2'b01 : (op == 4'hB) ? 2'b10 : 2'b00;
            if (op == 4'hB) begin
               e.zer = z; e.pcw = 1'b1; e.pcs = z; e.ret = 1'b1; cur.push_back(e);
            end else if (op == 4'h0 || op == 4'h2) begin
               cur.push_back(e);
               e = mk(3'd4, ins); e.rw = 1'b1; e.pcw = 1'b1; e.ret = 1'b1; cur.push_back(e);
            end else begin
               cur.push_back(e);
               if (mto) begin
                  for (int i = 0; i < WAIT_MAX; i++) begin
                     e = mk(3'd3, ins); e.rdy = 1'b0; e.mr = (op == 4'h4); e.mw = (op == 4'h5);
                     e.seterr = (i == WAIT_MAX - 1);
                     cur.push_back(e);
                  end
                  halt_tail(ins);
               end else begin
                  for (int i = 0; i < mw; i++) begin
                     e = mk(3'd3, ins); e.rdy = 1'b0; e.mr = (op == 4'h4); e.mw = (op == 4'h5);
                     cur.push_back(e);
                  end
                  e = mk(3'd3, ins); e.rdy = 1'b1; e.mr = (op == 4'h4); e.mw = (op == 4'h5);
                  if (op == 4'h5) begin e.pcw = 1'b1; e.ret = 1'b1; end
                  cur.push_back(e);
                  if (op == 4'h4) begin
                     e = mk(3'd4, ins); e.rw = 1'b1; e.pcw = 1'b1; e.wds = 1'b1; e.ret = 1'b1;
                     cur.push_back(e);
                  end
               end
            end
         end
      end
      if (abort_at >= 0 && abort_at < cur.size()) begin
         e = cur[abort_at];
         e.rst = 1'b1;
         {e.irw, e.mr, e.mw, e.rw, e.pcw, e.pcs, e.wds, e.alu, e.ret, e.seterr} = '0;
         while (cur.size() > abort_at) void'(cur.pop_back());
         cur.push_back(e);
      end
   endtask

   task automatic play(input string tag);
      ent_t e;
      logic [13:0] obs, exp;
      foreach (cur[k]) begin
         e = cur[k];
         reset = e.rst; mem_ready = e.rdy; zero = e.zer; instruction = e.ins;
         @(negedge clk);
         obs = {state, halted, mem_err, IRWrite, MemRead, MemWrite, RegWrite, PCWrite,
                PCSrc, ALUOp, WdSel};
         exp = {e.st, (e.st == 3'd7), err_m, e.irw, e.mr, e.mw, e.rw, e.pcw,
                e.pcs, e.alu, e.wds};
         check({tag, "_out"}, 32'(obs), 32'(exp));
         check({tag, "_cnt"}, 32'(instr_count), 32'(cnt_m));
         @(posedge clk);
         cyc++;
         if (e.rst) begin
            cnt_m = '0; err_m = 1'b0;
         end else begin
            if (e.ret) cnt_m = cnt_m + 1'b1;
            if (e.seterr) err_m = 1'b1;
         end
         #1;
      end
      reset = 1'b0;
   endtask

   function automatic logic [3:0] pick_op();
      int r = $urandom_range(0, 19);
      if (r < 3)  return 4'h0;
      if (r < 6)  return 4'h2;
      if (r < 9)  return 4'hB;
      if (r < 13) return 4'h4;
      if (r < 17) return 4'h5;
      if (r < 19) begin
         logic [3:0] o;
         do o = 4'($urandom); while (legal(o) || o == 4'hF);
         return o;
      end
      return 4'hF;
   endfunction

   initial begin
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; instruction = 16'h0000;
      cnt_m = '0; err_m = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_count", 32'(instr_count), 32'd0);
      check("rst_err", 32'(mem_err), 32'd0);
      check("rst_strobes", 32'({IRWrite, MemRead, MemWrite, RegWrite, PCWrite}), 32'd0);
      reset = 1'b0;

      build(4'h0, 0, 0, 1'b0, 0, 0, -1); play("add");
      build(4'h4, 0, 3, 1'b0, 0, 0, -1); play("lw_wait3");
      build(4'hB, 0, 0, 1'b1, 0, 0, -1); play("beq_z1");
      build(4'hB, 0, 0, 1'b0, 0, 0, -1); play("beq_z0");
      build(4'h7, 0, 0, 1'b0, 0, 0, -1); play("illegal");
      build(4'hF, 0, 0, 1'b0, 0, 0, -1); play("halt");
      build(4'h0, 0, 0, 1'b0, 1, 0, -1); play("fetch_tmo");
      build(4'h0, 14, 0, 1'b0, 0, 0, -1); play("fetch_w14");
      build(4'h5, 0, 0, 1'b0, 0, 1, -1); play("mem_tmo");
      build(4'h4, 0, 14, 1'b0, 0, 0, -1); play("mem_w14");
      for (int i = 0; i < 16; i++) begin
         build(4'h2, 0, 0, 1'b0, 0, 0, -1); play("wrap");
      end
      build(4'h5, 0, 3, 1'b0, 0, 0, 4); play("sw_abort");

      for (int n = 0; n < 300; n++) begin
         logic [3:0] op = pick_op();
         int  fw  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
         int  mw  = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
         bit  fto = ($urandom_range(0, 29) == 0);
         bit  mto = ($urandom_range(0, 14) == 0);
         int  ab  = -1;
         build(op, fw, mw, 1'($urandom), fto, mto, -1);
         if ($urandom_range(0, 11) == 0) begin
            ab = $urandom_range(0, cur.size() - 1);
            build(op, fw, mw, 1'($urandom), fto, mto, ab);
         end
         play("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
